// File: rtl/fb_divider_prog_if.sv
// rtl/fb_divider_prog_if.sv - control and status bundle of the programmable feedback divider
interface fb_divider_prog_if #(
  parameter int CNT_W  = 8,
  parameter int PCNT_W = 16
) ();
  logic              en;
  logic [CNT_W-1:0]  div_n;
  logic              div_load;
  logic              clk_fb;
  logic              fb_edge;
  logic              upd_done;
  logic              upd_pend;
  logic [CNT_W-1:0]  n_active;
  logic [PCNT_W-1:0] fb_periods;

  modport master (
    output en, div_n, div_load,
    input  clk_fb, fb_edge, upd_done, upd_pend, n_active, fb_periods
  );

  modport slave (
    input  en, div_n, div_load,
    output clk_fb, fb_edge, upd_done, upd_pend, n_active, fb_periods
  );
endinterface

// File: rtl/fb_divider_prog.sv
// rtl/fb_divider_prog.sv - programmable PLL feedback divider with boundary-aligned ratio updates
module fb_divider_prog #(
  parameter int CNT_W     = 8,
  parameter int DEFAULT_N = 4,
  parameter int PCNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  fb_divider_prog_if.slave    bus
);
  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEFAULT_N);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  n_active_q, n_active_d;
  logic [CNT_W-1:0]  pend_n_q, pend_n_d;
  logic              upd_pend_q, upd_pend_d;
  logic              clk_fb_q, clk_fb_d;
  logic              fb_edge_q, fb_edge_d;
  logic              upd_done_q, upd_done_d;
  logic [PCNT_W-1:0] fb_periods_q, fb_periods_d;

  // One extra bit so ceil(N/2) and cnt+1 do not overflow at N = 2**CNT_W-1
  logic [CNT_W:0]    half;
  logic [CNT_W:0]    cnt_inc;
  logic              wrap;
  logic [CNT_W-1:0]  load_n;

  always_comb begin
    half    = ({1'b0, n_active_q} + (CNT_W+1)'(1)) >> 1;
    cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    wrap    = (cnt_q == n_active_q - ONE);
    load_n  = (bus.div_n < TWO) ? TWO : bus.div_n;

    cnt_d        = cnt_q;
    n_active_d   = n_active_q;
    pend_n_d     = pend_n_q;
    upd_pend_d   = upd_pend_q;
    clk_fb_d     = clk_fb_q;
    fb_edge_d    = 1'b0;
    upd_done_d   = 1'b0;
    fb_periods_d = fb_periods_q;

    if (bus.en) begin
      if (wrap) begin
        cnt_d     = '0;
        clk_fb_d  = 1'b1;
        fb_edge_d = 1'b1;
        if (fb_periods_q != '1) begin
          fb_periods_d = fb_periods_q + PCNT_W'(1);
        end
        if (upd_pend_q) begin
          n_active_d = pend_n_q;
          upd_pend_d = 1'b0;
          upd_done_d = 1'b1;
        end
      end else begin
        cnt_d    = cnt_inc[CNT_W-1:0];
        clk_fb_d = (cnt_inc < half);
      end
    end else begin
      // Parking at n-1 makes the first enabled edge a wrap, i.e. a clean rise
      clk_fb_d = 1'b0;
      if (upd_pend_q) begin
        n_active_d = pend_n_q;
        cnt_d      = pend_n_q - ONE;
        upd_pend_d = 1'b0;
        upd_done_d = 1'b1;
      end else begin
        cnt_d = n_active_q - ONE;
      end
    end

    // Applied after the boundary logic so a load on a wrap edge stays pending
    if (bus.div_load) begin
      pend_n_d   = load_n;
      upd_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= DEF_N - ONE;
      n_active_q   <= DEF_N;
      pend_n_q     <= DEF_N;
      upd_pend_q   <= 1'b0;
      clk_fb_q     <= 1'b0;
      fb_edge_q    <= 1'b0;
      upd_done_q   <= 1'b0;
      fb_periods_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      n_active_q   <= n_active_d;
      pend_n_q     <= pend_n_d;
      upd_pend_q   <= upd_pend_d;
      clk_fb_q     <= clk_fb_d;
      fb_edge_q    <= fb_edge_d;
      upd_done_q   <= upd_done_d;
      fb_periods_q <= fb_periods_d;
    end
  end

  assign bus.clk_fb     = clk_fb_q;
  assign bus.fb_edge    = fb_edge_q;
  assign bus.upd_done   = upd_done_q;
  assign bus.upd_pend   = upd_pend_q;
  assign bus.n_active   = n_active_q;
  assign bus.fb_periods = fb_periods_q;
endmodule

// File: tb/tb_fb_divider_prog.sv
// tb/tb_fb_divider_prog.sv - self-checking bench for fb_divider_prog
module tb_fb_divider_prog;
  localparam int CNT_W  = 8;
  localparam int PCNT_W = 5;
  localparam int PMAX   = 31;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fb_divider_prog_if #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) bus ();

  fb_divider_prog #(.CNT_W(CNT_W), .DEFAULT_N(4), .PCNT_W(PCNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int clk_fb;
    int fb_edge;
    int upd_done;
    int upd_pend;
    int n_active;
    int fb_periods;
  } exp_t;

  typedef struct {
    bit r;
    bit e;
    bit l;
    int dn;
    int cycles;
    int exp_n;
  } seg_t;

  exp_t sb_q[$];

  int m_n, m_cnt, m_pv, m_per;
  bit m_clk, m_edge, m_done, m_pend;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model(bit r, bit e, bit l, int dn);
    int  n0   = m_n;
    int  c0   = m_cnt;
    int  h    = (m_n + 1) / 2;
    bit  wrap = (m_cnt == m_n - 1);
    exp_t x;
    if (!r) begin
      m_n = 4; m_cnt = 3; m_clk = 0; m_edge = 0; m_done = 0; m_pend = 0; m_per = 0;
    end else begin
      m_edge = 0;
      m_done = 0;
      if (e) begin
        if (wrap) begin
          m_cnt = 0; m_clk = 1; m_edge = 1;
          if (m_per < PMAX) m_per++;
          if (m_pend) begin m_n = m_pv; m_pend = 0; m_done = 1; end
        end else begin
          m_cnt = c0 + 1;
          m_clk = (c0 + 1 < h);
        end
      end else begin
        m_clk = 0;
        if (m_pend) begin
          m_n = m_pv; m_cnt = m_pv - 1; m_pend = 0; m_done = 1;
        end else begin
          m_cnt = n0 - 1;
        end
      end
      if (l) begin
        m_pv   = (dn < 2) ? 2 : dn;
        m_pend = 1;
      end
    end
    x.clk_fb = m_clk; x.fb_edge = m_edge; x.upd_done = m_done;
    x.upd_pend = m_pend; x.n_active = m_n; x.fb_periods = m_per;
    sb_q.push_back(x);
  endtask

  task automatic step(bit r, bit e, bit l, int dn);
    exp_t x;
    rst_n        = r;
    bus.en       = e;
    bus.div_load = l;
    bus.div_n    = CNT_W'(dn);
    model(r, e, l, dn);
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      x = sb_q.pop_front();
      chk("clk_fb",     int'(bus.clk_fb),     x.clk_fb);
      chk("fb_edge",    int'(bus.fb_edge),    x.fb_edge);
      chk("upd_done",   int'(bus.upd_done),   x.upd_done);
      chk("upd_pend",   int'(bus.upd_pend),   x.upd_pend);
      chk("n_active",   int'(bus.n_active),   x.n_active);
      chk("fb_periods", int'(bus.fb_periods), x.fb_periods);
    end
  endtask

  task automatic wait_done(int max_cycles);
    bit seen = 0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      step(1, 1, 0, 0);
      if (bus.upd_done) seen = 1;
    end
    chk("wait_upd_done", int'(seen), 1);
    chk("upd_done_with_edge", int'(bus.fb_edge), 1);
  endtask

  seg_t tbl[9];
  logic [7:0] pat;
  logic [7:0] pat2;
  int   pulses;

  initial begin
    tbl[0] = '{r:1, e:1, l:1, dn:3,   cycles:20,  exp_n:3};
    tbl[1] = '{r:1, e:1, l:1, dn:255, cycles:600, exp_n:255};
    tbl[2] = '{r:1, e:1, l:1, dn:1,   cycles:300, exp_n:2};
    tbl[3] = '{r:1, e:0, l:1, dn:9,   cycles:3,   exp_n:9};
    tbl[4] = '{r:1, e:1, l:0, dn:0,   cycles:30,  exp_n:9};
    tbl[5] = '{r:1, e:1, l:1, dn:6,   cycles:1,   exp_n:9};
    tbl[6] = '{r:1, e:1, l:1, dn:3,   cycles:15,  exp_n:3};
    tbl[7] = '{r:0, e:1, l:1, dn:7,   cycles:1,   exp_n:4};
    tbl[8] = '{r:1, e:1, l:0, dn:0,   cycles:10,  exp_n:4};

    rst_n = 1'b0; bus.en = 1'b0; bus.div_load = 1'b0; bus.div_n = '0;
    m_pv = 4;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    for (int s = 0; s < 9; s++) begin
      for (int k = 0; k < tbl[s].cycles; k++)
        step(tbl[s].r, tbl[s].e, tbl[s].l && (k == 0), tbl[s].dn);
      chk($sformatf("table_n_active_%0d", s), int'(bus.n_active), tbl[s].exp_n);
    end

    // Default ratio from reset: 1,1,0,0 with an edge every fourth cycle
    step(0, 0, 0, 0);
    chk("rst_n_active", int'(bus.n_active), 4);
    chk("rst_clk_fb", int'(bus.clk_fb), 0);
    pat  = 8'b11001100;
    pat2 = 8'b10001000;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 0);
      chk("dflt_clk_fb", int'(bus.clk_fb), int'(pat[7-i]));
      chk("dflt_fb_edge", int'(bus.fb_edge), int'(pat2[7-i]));
    end
    chk("dflt_periods", int'(bus.fb_periods), 2);

    // Load 5 while cnt==1: old period completes, then 1,1,1,0,0
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 5);
    chk("ld5_pend", int'(bus.upd_pend), 1);
    chk("ld5_not_yet", int'(bus.n_active), 4);
    pat  = 8'b01110010;
    pat2 = 8'b01000000;
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 0, 0);
      chk("ld5_clk_fb", int'(bus.clk_fb), int'(pat[7-i]));
      chk("ld5_upd_done", int'(bus.upd_done), int'(pat2[7-i]));
    end
    chk("ld5_n_active", int'(bus.n_active), 5);

    // Two loads inside one period: last wins, single pulse
    step(1, 1, 1, 6);
    step(1, 1, 1, 3);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 0);
      if (bus.upd_done) pulses++;
    end
    chk("last_wins_pulses", pulses, 1);
    chk("last_wins_n", int'(bus.n_active), 3);

    // div_n=0 clamps to 2: 1,0 pattern
    step(1, 1, 1, 0);
    wait_done(20);
    chk("clamp_n_active", int'(bus.n_active), 2);
    pat = 8'b01010000;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0);
      chk("clamp_clk_fb", int'(bus.clk_fb), int'(pat[7-i]));
    end

    // Disable during high phase, then re-enable for a full period
    step(1, 1, 1, 4);
    wait_done(20);
    chk("dis_high_before", int'(bus.clk_fb), 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      chk("dis_clk_fb", int'(bus.clk_fb), 0);
      chk("dis_fb_edge", int'(bus.fb_edge), 0);
    end
    pat = 8'b11001000;
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0);
      chk("reen_clk_fb", int'(bus.clk_fb), int'(pat[7-i]));
    end

    // Reset with a ratio pending drops it
    step(1, 1, 1, 7);
    step(0, 1, 0, 0);
    chk("rst_mid_clk_fb", int'(bus.clk_fb), 0);
    chk("rst_mid_pend", int'(bus.upd_pend), 0);
    chk("rst_mid_n", int'(bus.n_active), 4);
    chk("rst_mid_periods", int'(bus.fb_periods), 0);
    pat = 8'b11001100;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 0);
      chk("post_rst_clk_fb", int'(bus.clk_fb), int'(pat[7-i]));
    end
    chk("post_rst_n", int'(bus.n_active), 4);

    // Period counter saturation
    step(1, 1, 1, 0);
    for (int i = 0; i < 80; i++) step(1, 1, 0, 0);
    chk("sat_periods", int'(bus.fb_periods), PMAX);

    // Random mix of enable, load and occasional reset
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 7) == 0,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(2, 12)));
    end
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
